// File: rtl/conv11_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// conv11_pkg
// Shared definitions for the 1x1 convolution sequencer slice.
//   - default geometry constants (map side, output channels, MAC input count)
//   - default tag field widths used by the pipeline tag struct
//   - sequencer state enum
//   - pipeline tag struct {ch, addr} carried alongside each issued pixel
// Note: tag_t is sized by CH_W_DEF/ADDR_W_DEF, so a top-level instance that
// overrides CH_W or ADDR_W must keep them equal to these defaults.
// ---------------------------------------------------------------------------
package conv11_pkg;

   localparam int MAP_SIZE_DEF = 6;
   localparam int OUT_CH_DEF   = 16;
   localparam int IN_CH        = 12;

   localparam int CH_W_DEF     = 4;
   localparam int ADDR_W_DEF   = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [CH_W_DEF-1:0]   ch;
      logic [ADDR_W_DEF-1:0] addr;
   } tag_t;

endpackage

// File: rtl/conv11_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv11_seq_ctrl_if
// Result stream between the sequencer and the output feature buffer.
//   out_valid  result valid (master -> slave)
//   out_ready  downstream accept (slave -> master)
//   out_data   MAC result, OUT_WIDTH bits
//   out_ch     output-channel tag, CH_W bits
//   out_addr   pixel tag, ADDR_W bits
// A transfer happens on a rising edge where out_valid and out_ready are both
// high; the payload is held stable while out_valid is high and not accepted.
// ---------------------------------------------------------------------------
interface conv11_seq_ctrl_if #(
   parameter int OUT_WIDTH = 32,
   parameter int CH_W      = 4,
   parameter int ADDR_W    = 6
);

   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic [CH_W-1:0]      out_ch;
   logic [ADDR_W-1:0]    out_addr;

   modport master (
      output out_valid,
      output out_data,
      output out_ch,
      output out_addr,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_ch,
      input  out_addr,
      output out_ready
   );

endinterface

// File: rtl/conv11_seq_ctrl_addr_gen.sv
// ---------------------------------------------------------------------------
// conv11_addr_gen
// Pixel / output-channel walk for the 1x1 convolution sequencer.
// Pixel is the inner loop (0..MAP_SIZE^2-1), channel the outer loop
// (0..num_ch-1). On the pixel wrap the channel steps in the same advance, so
// consecutive channels are issued back to back.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        force both counters to 0 (used when a run is accepted)
//   advance      step the walk by one pixel
//   num_ch       number of channels in this run (already clamped, >= 1)
//   pix, ch      current pixel address and channel index
//   last_pixel   current pixel is the last one of a channel
//   last_all     current pixel is the last one of the last channel
// ---------------------------------------------------------------------------
module conv11_addr_gen #(
   parameter int MAP_SIZE = 6,
   parameter int ADDR_W   = 6,
   parameter int CH_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   input  logic [CH_W:0]     num_ch,
   output logic [ADDR_W-1:0] pix,
   output logic [CH_W-1:0]   ch,
   output logic              last_pixel,
   output logic              last_all
);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(MAP_SIZE * MAP_SIZE - 1);

   logic [ADDR_W-1:0] pix_q, pix_d;
   logic [CH_W-1:0]   ch_q,  ch_d;

   // End-of-channel and end-of-run flags are decoded from the current count so
   // the caller can act on them in the same cycle the final pixel is issued.
   always_comb begin
      last_pixel = (pix_q == LAST_PIX);
      last_all   = last_pixel && ({1'b0, ch_q} == (num_ch - 1'b1));
   end

   // Next-count logic: after the final pixel of the final channel both
   // counters fall back to 0, so the walk is ready for the next run.
   always_comb begin
      pix_d = pix_q;
      ch_d  = ch_q;
      if (clear) begin
         pix_d = '0;
         ch_d  = '0;
      end else if (advance) begin
         if (last_all) begin
            pix_d = '0;
            ch_d  = '0;
         end else if (last_pixel) begin
            pix_d = '0;
            ch_d  = ch_q + 1'b1;
         end else begin
            pix_d = pix_q + 1'b1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_q <= '0;
         ch_q  <= '0;
      end else begin
         pix_q <= pix_d;
         ch_q  <= ch_d;
      end
   end

   assign pix = pix_q;
   assign ch  = ch_q;

endmodule

// File: rtl/conv11_seq_ctrl.sv
// ---------------------------------------------------------------------------
// conv11_seq_ctrl
// Sequencer for the 12-input 1x1 convolution MAC. Walks every output channel
// and every pixel of a MAP_SIZE x MAP_SIZE map, drives the feature-buffer
// read, weight-bank select and MAC enable, and returns MAC results on a
// valid/ready stream tagged with channel and pixel.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle start pulse, accepted only in IDLE
//   cfg_num_ch    channels to run, latched at start, clamped to 1..OUT_CH
//   busy          high from the accepted start until done
//   done          one-cycle pulse the cycle after the last result handshake
//   fm_rd_en      feature-buffer read strobe (stage 0)
//   fm_rd_addr    row-major pixel address
//   w_sel         weight/bias bank select, aligned with mac_en (stage 1)
//   mac_en        MAC enable (stage 1)
//   conv_value    registered MAC result (stage 2)
//   out_if        result stream (master side)
// Build option: define CONV11_SEQ_RELU_EN to clamp negative results to 0 on
// the output; otherwise results pass through unmodified.
// ---------------------------------------------------------------------------
module conv11_seq_ctrl
   import conv11_pkg::*;
#(
   parameter int MAP_SIZE  = MAP_SIZE_DEF,
   parameter int OUT_CH    = OUT_CH_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int CH_W      = CH_W_DEF,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CH_W:0]        cfg_num_ch,
   output logic                 busy,
   output logic                 done,
   output logic                 fm_rd_en,
   output logic [ADDR_W-1:0]    fm_rd_addr,
   output logic [CH_W-1:0]      w_sel,
   output logic                 mac_en,
   input  logic [OUT_WIDTH-1:0] conv_value,
   conv11_seq_ctrl_if.master    out_if
);

   state_t          state_q, state_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [CH_W:0]   num_ch_q, num_ch_d;

   logic            s1_valid_q, s1_valid_d;
   tag_t            s1_tag_q, s1_tag_d;
   logic            s2_valid_q, s2_valid_d;
   tag_t            s2_tag_q, s2_tag_d;

   logic            advance;
   logic            issue;
   logic            final_issue;
   logic            accept_start;
   logic [ADDR_W-1:0] pix_cnt;
   logic [CH_W-1:0]   ch_cnt;
   logic            last_pixel;
   logic            last_all;
   logic [OUT_WIDTH-1:0] result;

   // The whole pipeline moves only when the output slot is free or being
   // accepted this cycle; a held result freezes every stage, including the
   // buffer and MAC strobes, so their registered data stays put.
   always_comb begin
      advance      = !(s2_valid_q && !out_if.out_ready);
      issue        = (state_q == RUN) && advance;
      final_issue  = issue && last_pixel && last_all;
      accept_start = (state_q == IDLE) && start;
   end

   conv11_addr_gen #(
      .MAP_SIZE (MAP_SIZE),
      .ADDR_W   (ADDR_W),
      .CH_W     (CH_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .clear      (accept_start),
      .advance    (issue),
      .num_ch     (num_ch_q),
      .pix        (pix_cnt),
      .ch         (ch_cnt),
      .last_pixel (last_pixel),
      .last_all   (last_all)
   );

   // Run-level control. The requested channel count is clamped on entry so
   // the walk always covers at least one and at most OUT_CH weight banks.
   // DRAIN ends on the handshake of the final result: stage 1 is already
   // empty and stage 2 holds the last result while out_ready is high.
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      num_ch_d = num_ch_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_num_ch == '0) begin
                  num_ch_d = (CH_W+1)'(1);
               end else if (cfg_num_ch > (CH_W+1)'(OUT_CH)) begin
                  num_ch_d = (CH_W+1)'(OUT_CH);
               end else begin
                  num_ch_d = cfg_num_ch;
               end
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (final_issue) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!s1_valid_q && s2_valid_q && out_if.out_ready) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pipeline valid/tag shifting. Tags ride with each issued pixel so the
   // result leaving stage 2 is labelled with the channel and pixel it was
   // computed for.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_tag_d   = s2_tag_q;
      if (advance) begin
         s1_valid_d = issue;
         if (issue) begin
            s1_tag_d = '{ch: ch_cnt, addr: pix_cnt};
         end
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_tag_d = s1_tag_q;
         end
      end
   end

   // State, control outputs and pipeline registers; reset aborts any run in
   // flight without producing a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         num_ch_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         num_ch_q   <= num_ch_d;
         s1_valid_q <= s1_valid_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   // Output stage conditioning applied directly to the MAC register, so it
   // adds no latency. The payload is forced to 0 whenever no result is
   // present, which also keeps it at 0 through reset.
   always_comb begin
`ifdef CONV11_SEQ_RELU_EN
      result = conv_value[OUT_WIDTH-1] ? '0 : conv_value;
`else
      result = conv_value;
`endif
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign fm_rd_en         = issue;
   assign fm_rd_addr       = pix_cnt;
   assign mac_en           = s1_valid_q && advance;
   assign w_sel            = s1_tag_q.ch;
   assign out_if.out_valid = s2_valid_q;
   assign out_if.out_data  = s2_valid_q ? result : '0;
   assign out_if.out_ch    = s2_tag_q.ch;
   assign out_if.out_addr  = s2_tag_q.addr;

endmodule

// File: tb/tb_conv11_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv11_seq_ctrl
// Directed-sequence bench for conv11_seq_ctrl with randomized data and
// randomized downstream back-pressure. A small feature buffer and MAC are
// emulated around the sequencer; every result is compared against the value
// expected for its channel/pixel, computed directly from the buffer, weight
// and bias tables. Honours CONV11_SEQ_RELU_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_conv11_seq_ctrl;

   localparam int MAP_SIZE  = 6;
   localparam int PIX       = MAP_SIZE * MAP_SIZE;
   localparam int OUT_CH    = 16;
   localparam int ADDR_W    = 6;
   localparam int CH_W      = 4;
   localparam int OUT_WIDTH = 32;
`ifdef CONV11_SEQ_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [CH_W:0]        cfg_num_ch;
   logic                 busy;
   logic                 done;
   logic                 fm_rd_en;
   logic [ADDR_W-1:0]    fm_rd_addr;
   logic [CH_W-1:0]      w_sel;
   logic                 mac_en;
   logic [OUT_WIDTH-1:0] conv_value;

   conv11_seq_ctrl_if #(
      .OUT_WIDTH (OUT_WIDTH),
      .CH_W      (CH_W),
      .ADDR_W    (ADDR_W)
   ) out_if ();

   conv11_seq_ctrl #(
      .MAP_SIZE  (MAP_SIZE),
      .OUT_CH    (OUT_CH),
      .ADDR_W    (ADDR_W),
      .CH_W      (CH_W),
      .OUT_WIDTH (OUT_WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_num_ch (cfg_num_ch),
      .busy       (busy),
      .done       (done),
      .fm_rd_en   (fm_rd_en),
      .fm_rd_addr (fm_rd_addr),
      .w_sel      (w_sel),
      .mac_en     (mac_en),
      .conv_value (conv_value),
      .out_if     (out_if)
   );

   int pix_mem [PIX];
   int wt      [OUT_CH];
   int bias    [OUT_CH];
   int pix_data;
   int cap_data [2];
   int total;
   int bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Feature buffer: registered read, data holds while the strobe is low.
   always @(posedge clk) begin
      if (fm_rd_en) pix_data <= pix_mem[fm_rd_addr];
   end

   // MAC: registered multiply-accumulate of the buffered pixel with the
   // selected weight bank, held while mac_en is low.
   always @(posedge clk) begin
      if (mac_en) conv_value <= pix_data * wt[w_sel] + bias[w_sel];
   end

   // Expected result for a given channel and pixel.
   function automatic int expVal(input int ch, input int addr);
      int v;
      v = pix_mem[addr] * wt[ch] + bias[ch];
      if (RELU && v < 0) v = 0;
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_busy"},       busy,             0);
      checkOutput({tag, "_done"},       done,             0);
      checkOutput({tag, "_fm_rd_en"},   fm_rd_en,         0);
      checkOutput({tag, "_fm_rd_addr"}, fm_rd_addr,       0);
      checkOutput({tag, "_w_sel"},      w_sel,            0);
      checkOutput({tag, "_mac_en"},     mac_en,           0);
      checkOutput({tag, "_out_valid"},  out_if.out_valid, 0);
      checkOutput({tag, "_out_data"},   out_if.out_data,  0);
      checkOutput({tag, "_out_ch"},     out_if.out_ch,    0);
      checkOutput({tag, "_out_addr"},   out_if.out_addr,  0);
   endtask

   task automatic randomizeTables();
      for (int p = 0; p < PIX; p++) pix_mem[p] = int'($urandom_range(0, 255));
      for (int c = 0; c < OUT_CH; c++) begin
         wt[c]   = int'($urandom_range(0, 255)) - 128;
         bias[c] = int'($urandom_range(0, 2000)) - 1000;
      end
   endtask

   // One run: mode 0 = out_ready always high, 1 = random out_ready,
   // 2 = random plus a 5-cycle hold at channel 0 pixel 17.
   // abort_at >= 0 asserts reset once that many results have been accepted;
   // restart_at >= 0 pulses start again on that cycle of the run.
   task automatic applyStimulus(input int cfg, input int mode,
                                input int abort_at, input int restart_at);
      int nch, total_res, budget, hs, issue_n, mac_n;
      int first_issue, first_valid, first_hs, last_hs, hold;
      bit held_once, finished, rdy;
      int exp_ch[$];
      int exp_addr[$];
      nch = (cfg == 0) ? 1 : ((cfg > OUT_CH) ? OUT_CH : cfg);
      total_res = nch * PIX;
      budget = total_res * 8 + 100;
      for (int c = 0; c < nch; c++) begin
         for (int p = 0; p < PIX; p++) begin
            exp_ch.push_back(c);
            exp_addr.push_back(p);
         end
      end
      hs = 0; issue_n = 0; mac_n = 0; hold = 0;
      first_issue = -1; first_valid = -1; first_hs = -1; last_hs = -1;
      held_once = 1'b0; finished = 1'b0;

      @(negedge clk);
      start = 1'b1;
      cfg_num_ch = cfg[CH_W:0];
      out_if.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg_num_ch = (CH_W+1)'($urandom_range(0, 31));

      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         if (hold > 0) begin
            rdy = 1'b0;
            hold--;
         end else if (mode == 2 && !held_once && out_if.out_valid &&
                      exp_ch.size() > 0 && exp_ch[0] == 0 && exp_addr[0] == 17) begin
            rdy = 1'b0;
            hold = 4;
            held_once = 1'b1;
         end else if (mode == 0) begin
            rdy = 1'b1;
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         out_if.out_ready = rdy;
         start = (cyc == restart_at);
         if (cyc == restart_at) cfg_num_ch = 5'd7;
         #1;

         if (fm_rd_en) begin
            checkOutput("issue_addr", fm_rd_addr, issue_n % PIX);
            if (first_issue < 0) first_issue = cyc;
            issue_n++;
         end
         if (mac_en) begin
            checkOutput("w_sel", w_sel, mac_n / PIX);
            mac_n++;
         end
         if (out_if.out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (exp_ch.size() == 0) begin
               checkOutput("extra_result", out_if.out_valid, 0);
            end else begin
               checkOutput("out_ch",   out_if.out_ch,   exp_ch[0]);
               checkOutput("out_addr", out_if.out_addr, exp_addr[0]);
               checkOutput("out_data", out_if.out_data, expVal(exp_ch[0], exp_addr[0]));
            end
            if (!rdy) begin
               checkOutput("stall_fm_rd_en", fm_rd_en, 0);
               checkOutput("stall_mac_en",   mac_en,   0);
            end
         end
         if (last_hs >= 0 && cyc == last_hs + 1) begin
            checkOutput("done_pulse",   done, 1);
            checkOutput("busy_at_done", busy, 0);
            finished = 1'b1;
         end else begin
            checkOutput("done_early", done, 0);
            checkOutput("busy_run",   busy, 1);
         end
         if (out_if.out_valid && rdy && exp_ch.size() > 0) begin
            if (hs < 2) cap_data[hs] = out_if.out_data;
            if (first_hs < 0) first_hs = cyc;
            void'(exp_ch.pop_front());
            void'(exp_addr.pop_front());
            hs++;
            if (exp_ch.size() == 0) last_hs = cyc;
            if (abort_at >= 0 && hs == abort_at) begin
               rst = 1'b1;
               #1;
               checkQuiet("abort");
               @(negedge clk);
               rst = 1'b0;
               out_if.out_ready = 1'b1;
               repeat (4) begin
                  @(negedge clk);
                  checkOutput("abort_no_done", done, 0);
                  checkOutput("abort_no_busy", busy, 0);
               end
               return;
            end
         end
         @(negedge clk);
      end

      checkOutput("run_completed", finished, 1);
      checkOutput("result_count", hs, total_res);
      checkOutput("issue_count", issue_n, total_res);
      checkOutput("first_latency", first_valid - first_issue, 2);
      if (mode == 0) checkOutput("no_gap_span", last_hs - first_hs, total_res - 1);
      @(negedge clk);
      checkOutput("idle_after_run", busy, 0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      start = 1'b0;
      cfg_num_ch = '0;
      out_if.out_ready = 1'b0;
      pix_data = 0;
      repeat (3) @(negedge clk);
      checkQuiet("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] single channel, fixed data for output clamp");
      randomizeTables();
      pix_mem[0] = 0;
      pix_mem[1] = 12;
      wt[0]      = 1;
      bias[0]    = -5;
      applyStimulus(1, 0, -1, -1);
      checkOutput("neg_result", cap_data[0], RELU ? 0 : -5);
      checkOutput("pos_result", cap_data[1], 7);

      $display("[TB] all 16 channels, no back-pressure");
      randomizeTables();
      applyStimulus(16, 0, -1, -1);

      $display("[TB] random back-pressure with long stall at pixel 17");
      randomizeTables();
      applyStimulus(5, 2, -1, -1);

      $display("[TB] start pulsed mid-run");
      randomizeTables();
      applyStimulus(3, 1, -1, 20);

      $display("[TB] zero channel request and oversize request");
      applyStimulus(0, 1, -1, -1);
      applyStimulus(17, 0, -1, -1);

      $display("[TB] reset mid-run then fresh run");
      randomizeTables();
      applyStimulus(4, 1, 10, -1);
      applyStimulus(2, 0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv11_seq_ctrl.md
Name: conv11_seq_ctrl

Overview:
- Sequencer for the 12-input 1x1 convolution MAC (12 channels x 8-bit in/weight, 1-cycle registered output).
- Walks every output channel and every pixel of a MAP_SIZE x MAP_SIZE feature map.
- Drives the feature-buffer read, weight-bank select and MAC enable, then returns MAC results on a valid/ready stream with channel and pixel tags.
- Sits between the layer FSM (start/done) and the output feature buffer.

Parameters:
- MAP_SIZE, 6, feature-map side; pixels per channel = MAP_SIZE*MAP_SIZE.
- OUT_CH, 16, maximum output channels (weight banks).
- ADDR_W, 6, pixel address width; must satisfy 2^ADDR_W >= MAP_SIZE*MAP_SIZE.
- CH_W, 4, channel index width; must satisfy 2^CH_W >= OUT_CH.
- OUT_WIDTH, 32, MAC result width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- cfg_num_ch  in  CH_W+1  output channels to run, 1..OUT_CH; latched at start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last result handshakes.
- fm_rd_en  out  1  feature-buffer read strobe. Data appears 1 cycle later and holds while fm_rd_en=0.
- fm_rd_addr  out  ADDR_W  pixel address, row-major.
- w_sel  out  CH_W  weight/bias bank select, aligned with mac_en.
- mac_en  out  1  MAC enable.
- conv_value  in  OUT_WIDTH  MAC registered result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_WIDTH  result.
- out_ch  out  CH_W  channel tag.
- out_addr  out  ADDR_W  pixel tag.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset mid-run aborts immediately; no done pulse is produced.
- FSM states:
  - IDLE: start latches cfg_num_ch. A value of 0 is clamped to 1; a value above OUT_CH is clamped to OUT_CH. Go to RUN.
  - RUN: issue one pixel per unstalled cycle. Pixel counter 0..MAP_SIZE^2-1 is the inner loop; channel counter 0..num_ch-1 is the outer loop. After issuing the last pixel of the last channel, go to DRAIN.
  - DRAIN: no new issues; wait for the pipeline to empty and the final out handshake, then go to DONE.
  - DONE: done=1 for one cycle, busy drops the same cycle, return to IDLE.
- Start while busy is ignored.
- Pipeline: 3 stages.
  - S0: fm_rd_en=1, fm_rd_addr=pixel.
  - S1: mac_en=1, w_sel=channel.
  - S2: out_valid=1, out_data=conv_value, tags carried through.
  - Latency from issue to out_valid is 2 cycles. Throughput is 1 result/cycle when out_ready=1.
- Stall: when out_valid=1 and out_ready=0, the whole pipeline freezes.
  - fm_rd_en=0 and mac_en=0, so the MAC and the buffer hold their values.
  - Tags, out_data and counters hold.
  - out_valid stays high and its payload is stable until the handshake.
- Handshake: a transfer occurs when out_valid && out_ready on the same rising edge. On transfer the next stage advances in that same cycle, so there is no bubble.
- Total results per run = num_ch*MAP_SIZE^2, emitted in order: channel-major, then pixel ascending.
- Wrap-around: the pixel counter wraps to 0 and the channel counter increments on the same cycle, with no idle gap between channels.
- out_ready may be high while out_valid=0; it has no effect.

Optional Feature:
- Macro: CONV11_SEQ_RELU_EN.
- Defined: out_data = 0 when conv_value is negative (signed MSB), otherwise conv_value. This is combinational on the S2 register, with no added latency.
- Undefined: out_data = conv_value unmodified.

Decomposition:
- Package conv11_pkg holds:
  - constants MAP_SIZE_DEF=6, OUT_CH_DEF=16, IN_CH=12;
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the tag struct {ch, addr}.
- Sub-module conv11_addr_gen: pixel/channel counters with advance, last_pixel and last_all outputs; instantiated once.
- The FSM and pipeline valid/tag registers live in the top module.

Test Plan:
- Reset, then start with cfg_num_ch=1 and out_ready=1 -> 36 results with out_addr 0..35, ch 0, first out_valid 2 cycles after the first fm_rd_en, done 1 cycle after the last handshake.
- cfg_num_ch=16, out_ready=1 -> 576 results in order; ch increments immediately after addr 35 with no gap; busy spans the run.
- out_ready toggled randomly and held low for 5 cycles at addr 17 -> out_data and tags stable while stalled, mac_en=0 and fm_rd_en=0 during the stall, no loss or duplication.
- start pulsed again mid-run and cfg_num_ch=0 at a later start -> mid-run start ignored; cfg_num_ch=0 runs as 1 channel.
- rst asserted at result 10 -> all outputs 0 asynchronously; a new start then runs a full sequence from addr 0.
- CONV11_SEQ_RELU_EN defined with conv_value=-5, then +7 -> out_data 0, then 7; with the macro undefined -> -5, then 7.
